// File: rtl/field_chi_expand_pkg.sv
// field_chi_expand_pkg: field constants, FSM state enum and field helpers shared
// by the chi-table expander. The field is the Mersenne prime p = 2^F_NBITS - 1.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q_P2_MI
`define F_Q_P2_MI 1
`endif

package field_chi_expand_pkg;

  localparam int F_NBITS = `F_NBITS;
  localparam int CHI_NVARS = 3;

  typedef logic [F_NBITS-1:0] fe_t;

  localparam fe_t F_Q = {F_NBITS{1'b1}};
  localparam fe_t F_ONE = fe_t'(1);
  // ~w == q - w for a Mersenne modulus, so 1 - w == ~w + (q + 2 - 2^n) == ~w + 1
  localparam fe_t F_Q_P2_MI = fe_t'(`F_Q_P2_MI);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OM,
    S_MUL_LO,
    S_MUL_HI,
    S_NEXT,
    S_DONE
  } chi_state_e;

  // table index width: clog2(2^nvars), never narrower than one bit
  function automatic int chi_idx_w(input int nvars);
    return ($clog2(2 ** nvars) < 1) ? 1 : $clog2(2 ** nvars);
  endfunction

  localparam int CHI_IDX_W = chi_idx_w(CHI_NVARS);

  // a + b mod q for a, b <= q
  function automatic fe_t f_add(input fe_t a, input fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  // fold a double-width product mod q using 2^n == 1
  function automatic fe_t f_red(input logic [2*F_NBITS-1:0] x);
    logic [F_NBITS:0] s;
    s = {1'b0, x[F_NBITS-1:0]} + {1'b0, x[2*F_NBITS-1:F_NBITS]};
    s = {1'b0, s[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s[F_NBITS]};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/field_chi_expand_if.sv
// field_chi_expand_if: start/point/table bus of the chi expander.
interface field_chi_expand_if
  import field_chi_expand_pkg::*;
#(
  parameter int NVARS = CHI_NVARS
);
  logic                              en;
  logic [NVARS-1:0][F_NBITS-1:0]     w;
  logic                              ready_pulse;
  logic                              ready;
  logic [2**NVARS-1:0][F_NBITS-1:0]  c;

  modport master(output en, w, input ready_pulse, ready, c);
  modport slave(input en, w, output ready_pulse, ready, c);
endinterface

// File: rtl/field_arith.sv
// field_arith: field one-minus unit (1 cycle) and serial field multiplier
// (2 cycles); each returns its result with a one-cycle ready_pulse.
module field_one_minus
  import field_chi_expand_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic start,
  input  fe_t  a,
  output fe_t  res,
  output logic ready_pulse
);

  // 1 - a as ~a + F_Q_P2_MI, registered with its strobe
  always_ff @(posedge clk) begin
    if (!rstb) begin
      res         <= '0;
      ready_pulse <= 1'b0;
    end else begin
      ready_pulse <= start;
      if (start) res <= f_add(~a, F_Q_P2_MI);
    end
  end

endmodule

module field_mul
  import field_chi_expand_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic start,
  input  fe_t  a,
  input  fe_t  b,
  output fe_t  res,
  output logic ready_pulse
);

  localparam int STAGES = 1;

  logic [STAGES:0]          vld_pipe;
  logic [2*F_NBITS-1:0]     prod;

  // valid bits track the product then the folded result
  always_ff @(posedge clk) begin
    if (!rstb) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], start};
  end

  // stage 0: full-width product; stage 1: modular fold
  always_ff @(posedge clk) begin
    if (!rstb) begin
      prod <= '0;
      res  <= '0;
    end else begin
      if (start)       prod <= (2*F_NBITS)'(a) * (2*F_NBITS)'(b);
      if (vld_pipe[0]) res  <= f_red(prod);
    end
  end

  assign ready_pulse = vld_pipe[STAGES];

endmodule

// File: rtl/field_chi_expand_step.sv
// field_chi_step_ctl: step/index counters and one-minus/multiplier issue
// sequencing for the chi expander. With FIELD_CHI_BOOL_BYPASS_EN defined, a
// step whose w_i is 0 or 1 completes in a single OM cycle.
module field_chi_step_ctl
  import field_chi_expand_pkg::*;
#(
  parameter int NVARS = CHI_NVARS,
  parameter int SW    = (NVARS > 1) ? $clog2(NVARS) : 1,
  parameter int JW    = (NVARS > 1) ? NVARS - 1 : 1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          en,
`ifdef FIELD_CHI_BOOL_BYPASS_EN
  input  logic          wi_bool,
  output logic          bool_step,
`endif
  input  logic          om_done,
  input  logic          mul_done,
  output chi_state_e    state,
  output logic [SW-1:0] step,
  output logic [JW-1:0] j,
  output logic          om_start,
  output logic          mul_start,
  output logic          init,
  output logic          om_latch,
  output logic          lo_latch,
  output logic          hi_write,
  output logic          finish
);

  chi_state_e nxt;
  logic       pend;
  logic       j_last;
  logic       step_last;

  assign step_last = (step == SW'(NVARS - 1));
  assign j_last    = (({1'b0, j} + (JW+1)'(1)) == ((JW+1)'(1) << step));

  // next state and per-cycle strobes; a unit is issued once, then its pulse awaited
  always_comb begin
    nxt       = state;
    om_start  = 1'b0;
    mul_start = 1'b0;
    init      = 1'b0;
    om_latch  = 1'b0;
    lo_latch  = 1'b0;
    hi_write  = 1'b0;
    finish    = 1'b0;
`ifdef FIELD_CHI_BOOL_BYPASS_EN
    bool_step = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (en) begin
          init = 1'b1;
          nxt  = S_OM;
        end
      end
      S_OM: begin
`ifdef FIELD_CHI_BOOL_BYPASS_EN
        if (!pend && wi_bool) begin
          bool_step = 1'b1;
          nxt       = S_NEXT;
        end else
`endif
        if (!pend) om_start = 1'b1;
        else if (om_done) begin
          om_latch = 1'b1;
          nxt      = S_MUL_LO;
        end
      end
      S_MUL_LO: begin
        if (!pend) mul_start = 1'b1;
        else if (mul_done) begin
          lo_latch = 1'b1;
          nxt      = S_MUL_HI;
        end
      end
      S_MUL_HI: begin
        if (!pend) mul_start = 1'b1;
        else if (mul_done) begin
          hi_write = 1'b1;
          nxt      = j_last ? S_NEXT : S_MUL_LO;
        end
      end
      S_NEXT: begin
        if (step_last) begin
          finish = 1'b1;
          nxt    = S_DONE;
        end else begin
          nxt = S_OM;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // state, outstanding-op flag and step/entry counters
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      step  <= '0;
      j     <= '0;
    end else begin
      state <= nxt;
      if (om_start || mul_start)                pend <= 1'b1;
      else if (om_latch || lo_latch || hi_write) pend <= 1'b0;
      if (init)                             step <= '0;
      else if (state == S_NEXT && !step_last) step <= step + SW'(1);
      if (om_latch)               j <= '0;
      else if (hi_write && !j_last) j <= j + JW'(1);
    end
  end

endmodule

// File: rtl/field_chi_expand.sv
// field_chi_expand: builds the multilinear chi table c[b] = prod_i (b_i ? w_i : 1-w_i)
// by in-place doubling with one shared multiplier. Optional FIELD_CHI_BOOL_BYPASS_EN
// shortcuts boolean coordinates; the table contents are identical either way.
module field_chi_expand
  import field_chi_expand_pkg::*;
#(
  parameter int NVARS = CHI_NVARS
) (
  input logic           clk,
  input logic           rstb,
  field_chi_expand_if.slave bus
);

  localparam int NT = 2 ** NVARS;
  localparam int TW = chi_idx_w(NVARS);
  localparam int SW = (NVARS > 1) ? $clog2(NVARS) : 1;
  localparam int JW = (NVARS > 1) ? NVARS - 1 : 1;

  chi_state_e                  state;
  logic [SW-1:0]               step;
  logic [JW-1:0]               j;
  logic                        om_start, mul_start, init, om_latch, lo_latch;
  logic                        hi_write, finish, om_done, mul_done;
  logic [NVARS-1:0][F_NBITS-1:0] w_q;
  logic [NT-1:0][F_NBITS-1:0]  t;
  logic [NT-1:0][F_NBITS-1:0]  c_q;
  fe_t                         om, lo, wi, tj, mul_b, om_res, mul_res;
  logic [TW-1:0]               lo_idx, hi_idx;

  assign wi     = w_q[step];
  assign lo_idx = TW'(j);
  assign hi_idx = lo_idx | (TW'(1) << step);
  assign tj     = t[lo_idx];
  assign mul_b  = (state == S_MUL_LO) ? om : wi;

`ifdef FIELD_CHI_BOOL_BYPASS_EN
  logic wi_zero, wi_one, bool_step;
  assign wi_zero = (wi == '0);
  assign wi_one  = (wi == F_ONE);
`endif

  field_chi_step_ctl #(.NVARS(NVARS), .SW(SW), .JW(JW)) u_ctl (
    .clk       (clk),
    .rstb      (rstb),
    .en        (bus.en),
`ifdef FIELD_CHI_BOOL_BYPASS_EN
    .wi_bool   (wi_zero | wi_one),
    .bool_step (bool_step),
`endif
    .om_done   (om_done),
    .mul_done  (mul_done),
    .state     (state),
    .step      (step),
    .j         (j),
    .om_start  (om_start),
    .mul_start (mul_start),
    .init      (init),
    .om_latch  (om_latch),
    .lo_latch  (lo_latch),
    .hi_write  (hi_write),
    .finish    (finish)
  );

  field_one_minus u_om (
    .clk         (clk),
    .rstb        (rstb),
    .start       (om_start),
    .a           (wi),
    .res         (om_res),
    .ready_pulse (om_done)
  );

  field_mul u_mul (
    .clk         (clk),
    .rstb        (rstb),
    .start       (mul_start),
    .a           (tj),
    .b           (mul_b),
    .res         (mul_res),
    .ready_pulse (mul_done)
  );

  // point capture, working table t, and the published table c
  always_ff @(posedge clk) begin
    if (!rstb) begin
      w_q <= '0;
      t   <= '0;
      om  <= '0;
      lo  <= '0;
      c_q <= '0;
    end else begin
      if (init) begin
        w_q <= bus.w;
        t   <= {{(NT-1)*F_NBITS{1'b0}}, F_ONE};
      end
      if (om_latch) om <= om_res;
      if (lo_latch) lo <= mul_res;
      // t[j] is replaced only once both of its products have been taken
      if (hi_write) begin
        t[hi_idx] <= mul_res;
        t[lo_idx] <= lo;
      end
`ifdef FIELD_CHI_BOOL_BYPASS_EN
      if (bool_step) begin
        for (int k = 0; k < NT/2; k++) begin
          if (TW'(k) < (TW'(1) << step)) begin
            t[TW'(k) | (TW'(1) << step)] <= wi_one ? t[k] : '0;
            if (wi_one) t[k] <= '0;
          end
        end
      end
`endif
      if (finish) c_q <= t;
    end
  end

  assign bus.ready       = (state == S_IDLE);
  assign bus.ready_pulse = (state == S_DONE);
  assign bus.c           = c_q;

endmodule

// File: tb/tb_field_chi_expand.sv
// tb_field_chi_expand: NVARS=2 and NVARS=3 instances checked against a
// product-of-factors chi model using plain modular arithmetic.
module tb_field_chi_expand;
  import field_chi_expand_pkg::*;

  localparam logic [63:0] P = (64'd1 << F_NBITS) - 64'd1;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int checks = 0;
  int errors = 0;
  int p2 = 0;
  int p3 = 0;

  field_chi_expand_if #(.NVARS(2)) b2();
  field_chi_expand_if #(.NVARS(3)) b3();

  field_chi_expand #(.NVARS(2)) dut2 (.clk(clk), .rstb(rstb), .bus(b2));
  field_chi_expand #(.NVARS(3)) dut3 (.clk(clk), .rstb(rstb), .bus(b3));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b2.ready_pulse) p2++;
    if (b3.ready_pulse) p3++;
  end

  typedef struct packed {
    fe_t [1:0] w;
    fe_t [3:0] c;
  } vec2_t;

  function automatic vec2_t mk(input fe_t w0, input fe_t w1, input fe_t c0,
                               input fe_t c1, input fe_t c2, input fe_t c3);
    vec2_t v;
    v.w[0] = w0; v.w[1] = w1;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    return v;
  endfunction

  function automatic fe_t mm(input fe_t a, input fe_t b);
    logic [127:0] x;
    x = (128'(a) * 128'(b)) % 128'(P);
    return x[F_NBITS-1:0];
  endfunction

  function automatic fe_t one_minus(input fe_t a);
    logic [63:0] r;
    r = (P + 64'd1 - 64'(a)) % P;
    return r[F_NBITS-1:0];
  endfunction

  function automatic fe_t chi_ref(input fe_t ws[3], input int n, input int b);
    fe_t acc;
    acc = fe_t'(1);
    for (int i = 0; i < n; i++) acc = mm(acc, b[i] ? ws[i] : one_minus(ws[i]));
    return acc;
  endfunction

  function automatic fe_t rand_fe();
    logic [63:0] r;
    case ($urandom_range(0, 5))
      0: r = 64'd0;
      1: r = 64'd1;
      2: r = P - 64'd1;
      default: r = {$urandom, $urandom} % P;
    endcase
    return r[F_NBITS-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_pulse(input int which, output int lat);
    lat = 0;
    while (((which == 2) ? !b2.ready_pulse : !b3.ready_pulse) && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= BUDGET) chk($sformatf("timeout_dut%0d", which), 64'(lat), 64'(BUDGET - 1));
  endtask

  // lat = clock edges from the edge that samples en to the ready_pulse cycle
  task automatic run2(input fe_t w0, input fe_t w1, output int lat);
    @(negedge clk);
    b2.w[0] = w0; b2.w[1] = w1; b2.en = 1'b1;
    @(negedge clk);
    b2.en = 1'b0;
    wait_pulse(2, lat);
    @(negedge clk);
  endtask

  task automatic run3(input fe_t ws[3], output int lat);
    @(negedge clk);
    for (int i = 0; i < 3; i++) b3.w[i] = ws[i];
    b3.en = 1'b1;
    @(negedge clk);
    b3.en = 1'b0;
    wait_pulse(3, lat);
    @(negedge clk);
  endtask

  task automatic chk_c3(input string tag, input fe_t ws[3]);
    logic [63:0] s;
    s = 0;
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("%s_c[%0d]", tag, b), 64'(b3.c[b]), 64'(chi_ref(ws, 3, b)));
      s = (s + 64'(b3.c[b])) % P;
    end
    chk({tag, "_sum"}, s, 64'd1);
  endtask

  initial begin
    vec2_t tbl[6];
    fe_t ws[3];
    fe_t wb[3];
    int lat;
    int base;
    logic [63:0] s;

    tbl[0] = mk(0, 0, 1, 0, 0, 0);
    tbl[1] = mk(2, 3, 2, fe_t'(P - 4), fe_t'(P - 3), 6);
    tbl[2] = mk(1, 1, 0, 0, 0, 1);
    tbl[3] = mk(1, 0, 0, 1, 0, 0);
    tbl[4] = mk(0, 1, 0, 0, 1, 0);
    tbl[5] = mk(fe_t'(P - 1), 2, fe_t'(P - 2), 1, 4, fe_t'(P - 2));

    b2.en = 1'b0; b2.w = '0;
    b3.en = 1'b0; b3.w = '0;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_ready2", 64'(b2.ready), 64'd1);
    chk("rst_pulse2", 64'(b2.ready_pulse), 64'd0);
    chk("rst_c2", 64'(b2.c == '0), 64'd1);
    chk("rst_ready3", 64'(b3.ready), 64'd1);
    chk("rst_pulse3", 64'(b3.ready_pulse), 64'd0);
    chk("rst_c3", 64'(b3.c == '0), 64'd1);

    // NVARS=2 table vectors
    for (int v = 0; v < 6; v++) begin
      base = p2;
      run2(tbl[v].w[0], tbl[v].w[1], lat);
      s = 0;
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("v%0d_c[%0d]", v, b), 64'(b2.c[b]), 64'(tbl[v].c[b]));
        s = (s + 64'(b2.c[b])) % P;
      end
      chk($sformatf("v%0d_sum", v), s, 64'd1);
      chk($sformatf("v%0d_ready", v), 64'(b2.ready), 64'd1);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_pulses", v), 64'(p2 - base), 64'd1);
    end

    // NVARS=3 random points
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 3; i++) ws[i] = rand_fe();
      base = p3;
      run3(ws, lat);
      chk_c3($sformatf("rnd%0d", r), ws);
      @(negedge clk);
      chk($sformatf("rnd%0d_pulses", r), 64'(p3 - base), 64'd1);
    end

    // en mid-run with another point, and en during the ready_pulse cycle
    for (int i = 0; i < 3; i++) begin
      ws[i] = fe_t'(64'd5 + 64'(i) * 64'd7);
      wb[i] = fe_t'(P - 64'd9 - 64'(i));
    end
    base = p3;
    @(negedge clk);
    for (int i = 0; i < 3; i++) b3.w[i] = ws[i];
    b3.en = 1'b1;
    @(negedge clk);
    b3.en = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) b3.w[i] = wb[i];
    b3.en = 1'b1;
    @(negedge clk);
    b3.en = 1'b0;
    wait_pulse(3, lat);
    b3.en = 1'b1;
    @(negedge clk);
    b3.en = 1'b0;
    chk("midrun_ready_after_pulse", 64'(b3.ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("midrun_still_idle", 64'(b3.ready), 64'd1);
    chk("midrun_pulses", 64'(p3 - base), 64'd1);
    chk_c3("midrun", ws);

    // reset while step 1 is multiplying, then a fresh run
    base = p2;
    @(negedge clk);
    b2.w[0] = 7; b2.w[1] = 9; b2.en = 1'b1;
    @(negedge clk);
    b2.en = 1'b0;
    repeat (15) @(negedge clk);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(b2.ready), 64'd1);
    chk("abort_c_cleared", 64'(b2.c == '0), 64'd1);
    repeat (60) @(negedge clk);
    chk("abort_no_stale_pulse", 64'(p2 - base), 64'd0);
    run2(1, 1, lat);
    for (int b = 0; b < 4; b++)
      chk($sformatf("abort_c[%0d]", b), 64'(b2.c[b]), (b == 3) ? 64'd1 : 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_pulses", 64'(p2 - base), 64'd1);

    // boolean point w=(1,0,1)
    ws[0] = 1; ws[1] = 0; ws[2] = 1;
    base = p3;
    run3(ws, lat);
    for (int b = 0; b < 8; b++)
      chk($sformatf("bool_c[%0d]", b), 64'(b3.c[b]), (b == 5) ? 64'd1 : 64'd0);
`ifdef FIELD_CHI_BOOL_BYPASS_EN
    chk("bool_latency", 64'(lat), 64'd6);
`endif
    @(negedge clk);
    chk("bool_pulses", 64'(p3 - base), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
